// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read-side stream adapter.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned BUF_DEPTH       = 2;
  localparam int unsigned OCC_WIDTH       = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } fifo_rd_state_e;

endpackage

// File: rtl/fifo_read_stream_if.sv
// FIFO read port plus valid/ready output stream, as seen by the read adapter.
interface fifo_read_stream_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
);

  logic                  rempty;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    input  rempty, rdata, m_ready,
    output rinc, m_valid, m_data
  );

  modport slave (
    output rempty, rdata, m_ready,
    input  rinc, m_valid, m_data
  );

endinterface

// File: rtl/fifo_read_stream_buf2.sv
// Two-entry in-order output buffer; head entry drives the stream data.
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  clear,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [OCC_WIDTH-1:0]  occ
);

  logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0] ent_q, ent_d;
  logic [OCC_WIDTH-1:0]                 occ_q, occ_d;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_comb begin
    ent_d = ent_q;
    occ_d = occ_q;
    if (clear) begin
      occ_d = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          ent_d[occ_q[0]] = push_data;
          occ_d           = occ_q + OCC_WIDTH'(1);
        end
        2'b01: begin
          ent_d[0] = ent_q[1];
          occ_d    = occ_q - OCC_WIDTH'(1);
        end
        2'b11: begin
          if (occ_q == OCC_WIDTH'(2)) begin
            ent_d[0] = ent_q[1];
            ent_d[1] = push_data;
          end else begin
            ent_d[0] = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q <= '0;
      occ_q <= '0;
    end else begin
      ent_q <= ent_d;
      occ_q <= occ_d;
    end
  end

  assign valid = (occ_q != '0);
  assign data  = ent_q[0];
  assign occ   = occ_q;

endmodule

// File: rtl/fifo_read_stream.sv
// Read-side adapter: pops the async FIFO into a full-rate valid/ready stream,
// with a drain-and-discard flush sequence and a delivered-word counter.
module fifo_read_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_read_stream_if.master   bus,
  input  logic                 flush,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_FLUSH = 2'(FLUSH);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  logic [1:0]           state_q, state_d;
  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [OCC_WIDTH-1:0] occ;
  logic                 pop, push, clear, rinc;
  logic [2:0]           lvl;

  assign pop = bus.m_valid && bus.m_ready;
  // Buffer level after this cycle's pop, counting the word still in flight.
  assign lvl = 3'(occ) + 3'(inflight_q) - 3'(pop);

  always_comb begin
    state_d = state_q;
    rinc    = 1'b0;
    push    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      ST_RUN: begin
        rinc = !bus.rempty && (lvl < 3'd2);
        push = inflight_q && !flush;
        if (flush) begin
          clear   = 1'b1;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        rinc = !bus.rempty;
        if (bus.rempty && !inflight_q) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    // No pops while held in reset, so no word is lost to a read nobody captures.
    if (rst) rinc = 1'b0;
  end

  assign inflight_d = rinc;
  assign cnt_d      = pop ? cnt_q + CNT_WIDTH'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  stream_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.rdata),
    .pop       (pop),
    .clear     (clear),
    .valid     (bus.m_valid),
    .data      (bus.m_data),
    .occ       (occ)
  );

  assign bus.rinc   = rinc;
  assign flush_busy = (state_q == ST_FLUSH);
  assign flush_done = (state_q == ST_DONE);
  assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream: behavioural FIFO read port plus an in-order scoreboard.
module tb_fifo_read_stream;
  import fifo_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          flush_busy;
  logic          flush_done;
  logic [CW-1:0] word_cnt;

  fifo_read_stream_if #(.DATA_WIDTH(DW)) bus ();

  fifo_read_stream #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem[$];
  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w;
  int n_vec = 0;
  int n_err = 0;
  int rinc_cnt = 0;
  int exp_cnt = 0;

  // FIFO read port: registered rdata, writes become visible one edge after being queued.
  always @(posedge clk) begin
    if (bus.rinc === 1'b1) begin
      if (mem.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL fifo_underflow: rinc=1 with empty FIFO, required rinc=0");
      end else begin
        bus.rdata <= mem.pop_front();
        rinc_cnt++;
      end
    end
    while (wr_q.size() > 0) mem.push_back(wr_q.pop_front());
    bus.rempty <= (mem.size() == 0);
  end

  // Scoreboard: every handshake must deliver the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: m_data=%h delivered, required no word", bus.m_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (bus.m_data !== exp_w) begin
          n_err++;
          $display("FAIL sb_data: m_data=%h, required %h", bus.m_data, exp_w);
        end
      end
      exp_cnt++;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_q.push_back(DW'(base + DW'(i)));
      exp_q.push_back(DW'(base + DW'(i)));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.m_ready = 1'b0;
    cyc(3);
    rst = 1'b0;
    n_vec++;
    if (bus.rinc !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== '0) begin
      n_err++;
      $display("FAIL reset_stream: rinc=%b m_valid=%b m_data=%h, required 0 0 00",
               bus.rinc, bus.m_valid, bus.m_data);
    end
    n_vec++;
    if (flush_busy !== 1'b0 || flush_done !== 1'b0 || word_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: busy=%b done=%b word_cnt=%0d, required 0 0 0",
               flush_busy, flush_done, word_cnt);
    end
  endtask

  task automatic test_stream();
    int t_rinc = -1;
    int t_val = -1;
    int last_val = -1;
    int n_val = 0;
    int r0 = rinc_cnt;
    bus.m_ready = 1'b1;
    put(8'h11, 4);
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (bus.rinc === 1'b1 && t_rinc < 0) t_rinc = c;
      if (bus.m_valid === 1'b1) begin
        if (t_val < 0) t_val = c;
        n_val++;
        last_val = c;
      end
    end
    n_vec++;
    if (t_val - t_rinc != 2) begin
      n_err++;
      $display("FAIL stream_latency: %0d cycles rinc->m_valid, required 2", t_val - t_rinc);
    end
    n_vec++;
    if (n_val != 4 || last_val - t_val != 3) begin
      n_err++;
      $display("FAIL stream_gapless: %0d valid cycles over span %0d, required 4 over 3",
               n_val, last_val - t_val);
    end
    n_vec++;
    if (word_cnt !== 4'd4) begin
      n_err++;
      $display("FAIL stream_cnt: word_cnt=%0d, required 4", word_cnt);
    end
    n_vec++;
    if (bus.rinc !== 1'b0 || rinc_cnt - r0 != 4 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stream_drain: rinc=%b pops=%0d pending=%0d, required 0 4 0",
               bus.rinc, rinc_cnt - r0, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int r0 = rinc_cnt;
    int unstable = 0;
    int n_hs = 0;
    bus.m_ready = 1'b0;
    put(8'h11, 6);
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (bus.m_valid === 1'b1 && bus.m_data !== 8'h11) unstable++;
    end
    n_vec++;
    if (rinc_cnt - r0 != 2 || mem.size() != 4) begin
      n_err++;
      $display("FAIL bp_pops: pops=%0d fifo_left=%0d, required 2 4", rinc_cnt - r0, mem.size());
    end
    n_vec++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h11 || unstable != 0) begin
      n_err++;
      $display("FAIL bp_hold: m_valid=%b m_data=%h unstable=%0d, required 1 11 0",
               bus.m_valid, bus.m_data, unstable);
    end
    bus.m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.m_valid === 1'b1) n_hs++;
      cyc();
    end
    n_vec++;
    if (n_hs != 6 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_release: %0d handshakes in 6 cycles, %0d pending, required 6 0",
               n_hs, exp_q.size());
    end
    cyc(2);
  endtask

  task automatic test_flush();
    int r0;
    int n_busy = 0;
    int n_done = 0;
    int bad_valid = 0;
    logic [CW-1:0] c0;
    bus.m_ready = 1'b0;
    put(8'h21, 5);
    cyc(8);
    r0 = rinc_cnt;
    c0 = word_cnt;
    n_vec++;
    if (bus.m_valid !== 1'b1 || mem.size() != 3) begin
      n_err++;
      $display("FAIL flush_setup: m_valid=%b fifo_left=%0d, required 1 3", bus.m_valid, mem.size());
    end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    n_vec++;
    if (bus.m_valid !== 1'b0 || flush_busy !== 1'b1) begin
      n_err++;
      $display("FAIL flush_enter: m_valid=%b busy=%b, required 0 1", bus.m_valid, flush_busy);
    end
    for (int c = 0; c < 20; c++) begin
      if (flush_busy === 1'b1) n_busy++;
      if (flush_done === 1'b1) n_done++;
      if (bus.m_valid === 1'b1) bad_valid++;
      cyc();
    end
    n_vec++;
    if (rinc_cnt - r0 != 3 || mem.size() != 0) begin
      n_err++;
      $display("FAIL flush_drain: pops=%0d fifo_left=%0d, required 3 0", rinc_cnt - r0, mem.size());
    end
    n_vec++;
    if (n_busy != 5 || n_done != 1 || bad_valid != 0) begin
      n_err++;
      $display("FAIL flush_seq: busy=%0d done=%0d valid=%0d cycles, required 5 1 0",
               n_busy, n_done, bad_valid);
    end
    n_vec++;
    if (word_cnt !== c0) begin
      n_err++;
      $display("FAIL flush_cnt: word_cnt=%0d, required %0d", word_cnt, c0);
    end
    exp_q.delete();
  endtask

  task automatic test_flush_pop();
    int guard = 0;
    logic [CW-1:0] c0;
    bus.m_ready = 1'b0;
    put(8'h31, 3);
    cyc(6);
    c0 = word_cnt;
    bus.m_ready = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    put(8'h41, 2);
    n_vec++;
    if (word_cnt !== CW'(c0 + 1) || bus.m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fpop_count: word_cnt=%0d m_valid=%b, required %0d 0",
               word_cnt, bus.m_valid, CW'(c0 + 1));
    end
    while (flush_done !== 1'b1 && guard < 30) begin
      cyc();
      guard++;
    end
    n_vec++;
    if (guard >= 30) begin
      n_err++;
      $display("FAIL fpop_timeout: flush_done not seen in %0d cycles, required within 30", guard);
    end
    cyc();
    n_vec++;
    if (mem.size() != 0 || flush_busy !== 1'b0) begin
      n_err++;
      $display("FAIL fpop_late_writes: fifo_left=%0d busy=%b, required 0 0", mem.size(), flush_busy);
    end
    exp_q.delete();
    put(8'h5a, 1);
    cyc(6);
    n_vec++;
    if (exp_q.size() != 0 || word_cnt !== CW'(c0 + 2)) begin
      n_err++;
      $display("FAIL fpop_resume: pending=%0d word_cnt=%0d, required 0 %0d",
               exp_q.size(), word_cnt, CW'(c0 + 2));
    end
  endtask

  task automatic test_reset_inflight();
    int guard = 0;
    bus.m_ready = 1'b1;
    put(8'h61, 3);
    while (bus.rinc !== 1'b1 && guard < 10) begin
      cyc();
      guard++;
    end
    n_vec++;
    if (guard >= 10) begin
      n_err++;
      $display("FAIL rst_wait: no rinc in %0d cycles, required within 10", guard);
    end
    cyc();
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.rinc !== 1'b0) begin
      n_err++;
      $display("FAIL rst_rinc: rinc=%b during reset, required 0", bus.rinc);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== '0 || word_cnt !== '0 || flush_busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_outputs: m_valid=%b m_data=%h word_cnt=%0d busy=%b, required 0 00 0 0",
               bus.m_valid, bus.m_data, word_cnt, flush_busy);
    end
    void'(exp_q.pop_front());
    exp_cnt = 0;
    cyc(8);
    n_vec++;
    if (exp_q.size() != 0 || word_cnt !== 4'd2) begin
      n_err++;
      $display("FAIL rst_resume: pending=%0d word_cnt=%0d, required 0 2", exp_q.size(), word_cnt);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_cnt = 0;
    bus.m_ready = 1'b1;
    put(8'h80, 17);
    cyc(30);
    n_vec++;
    if (exp_q.size() != 0 || word_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL wrap_cnt: pending=%0d word_cnt=%0d, required 0 1", exp_q.size(), word_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.m_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_pop();
    test_reset_inflight();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
